// File: rtl/soc_system_sysid_checker.sv
// soc_system_sysid_checker: Avalon-MM reader that fetches the system ID and build timestamp and compares them.
// Revision 1.0
`default_nettype none

module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h55D7EB21,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ID_REQ  = 3'd1;
  localparam logic [2:0] S_ID_DATA = 3'd2;
  localparam logic [2:0] S_TS_REQ  = 3'd3;
  localparam logic [2:0] S_TS_DATA = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam bit          LAT_ZERO = (READ_LATENCY == 0);
  localparam logic [1:0]  LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] tmo_cnt;
  logic [1:0]  lat_cnt;
  logic        in_req;
  logic        in_data;
  logic        accept;
  logic        cap_id;
  logic        cap_ts;
  logic        tmo_hit;
  logic        enter_req;

  always_comb begin
    in_req  = (state == S_ID_REQ) || (state == S_TS_REQ);
    in_data = (state == S_ID_DATA) || (state == S_TS_DATA);
    accept  = in_req && !avm_waitrequest;
    cap_id  = LAT_ZERO ? ((state == S_ID_REQ) && accept)
                       : ((state == S_ID_DATA) && (lat_cnt == LAT_LAST));
    cap_ts  = LAT_ZERO ? ((state == S_TS_REQ) && accept)
                       : ((state == S_TS_DATA) && (lat_cnt == LAT_LAST));
    // A read that has not delivered data by its last budgeted cycle is abandoned,
    // even if the request itself was accepted on that cycle.
    tmo_hit = (in_req || in_data) && (tmo_cnt == TMO_LAST) && !(cap_id || cap_ts);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_ID_REQ;
      S_ID_REQ:  if (tmo_hit)     state_next = S_FINISH;
                 else if (accept) state_next = LAT_ZERO ? S_TS_REQ : S_ID_DATA;
      S_ID_DATA: if (tmo_hit)     state_next = S_FINISH;
                 else if (cap_id) state_next = S_TS_REQ;
      S_TS_REQ:  if (tmo_hit)     state_next = S_FINISH;
                 else if (accept) state_next = LAT_ZERO ? S_FINISH : S_TS_DATA;
      S_TS_DATA: if (tmo_hit || cap_ts) state_next = S_FINISH;
      S_FINISH:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    avm_read    = (state == S_ID_REQ) || (state == S_TS_REQ);
    avm_address = (state == S_TS_REQ) || (state == S_TS_DATA);
    busy        = (state == S_ID_REQ) || (state == S_ID_DATA) ||
                  (state == S_TS_REQ) || (state == S_TS_DATA);
    done        = (state == S_FINISH);
  end

  assign enter_req = ((state_next == S_ID_REQ) && (state != S_ID_REQ)) ||
                     ((state_next == S_TS_REQ) && (state != S_TS_REQ));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= 16'd0;
      lat_cnt <= 2'd0;
    end else begin
      if (enter_req)             tmo_cnt <= 16'd0;
      else if (in_req || in_data) tmo_cnt <= tmo_cnt + 16'd1;
      if (in_req)       lat_cnt <= 2'd0;
      else if (in_data) lat_cnt <= lat_cnt + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else if ((state == S_IDLE) && start) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      if (cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TS);
      end
      if (tmo_hit) timeout <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for soc_system_sysid_checker: latency-0 instance plus a latency-2 / short-timeout instance.
// Revision 1.0
`default_nettype none

module tb_soc_system_sysid_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, start2;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic        avm_address2, avm_read2, avm_waitrequest2;
  logic [31:0] avm_readdata2;
  logic        busy2, done2, id_ok2, ts_ok2, timeout2;
  logic [31:0] id_value2, ts_value2;

  logic [31:0] id_word, ts_word;
  int          stall_n, stall_cnt;
  logic        stuck2;
  int          vectors = 0;
  int          miscompares = 0;
  int          at, dones;

  always #5 clock = ~clock;

  soc_system_sysid_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  soc_system_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(4)) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .avm_address(avm_address2), .avm_read(avm_read2),
    .avm_waitrequest(avm_waitrequest2), .avm_readdata(avm_readdata2),
    .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2), .timeout(timeout2),
    .id_value(id_value2), .ts_value(ts_value2)
  );

  // Responder: stalls each read for stall_n cycles, data presented from the address.
  assign avm_waitrequest  = avm_read && (stall_cnt < stall_n);
  assign avm_readdata     = avm_address ? ts_word : id_word;
  assign avm_waitrequest2 = avm_read2 && avm_address2 && stuck2;
  assign avm_readdata2    = avm_address2 ? ts_word : id_word;

  always @(posedge clock or posedge reset) begin
    if (reset)                                stall_cnt <= 0;
    else if (avm_read && !avm_waitrequest)    stall_cnt <= 0;
    else if (avm_read)                        stall_cnt <= stall_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit second, input int from, input int budget, output int cyc);
    cyc = from;
    while (!(second ? done2 : done) && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; stuck2 = 1'b0;
    stall_n = 0; id_word = 32'hACD51302; ts_word = 32'h55D7EB21;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    check("rst_values", id_value | ts_value, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: minimum-latency passing sequence
    pulse_start();
    check("t1_c1_read", {30'd0, avm_read, avm_address}, 32'd2);
    check("t1_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_c2_read", {30'd0, avm_read, avm_address}, 32'd3);
    tick();
    check("t1_c3_done", {30'd0, done, busy}, 32'd2);
    check("t1_c3_read", {31'd0, avm_read}, 32'd0);
    check("t1_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    check("t1_id_value", id_value, 32'hACD51302);
    check("t1_ts_value", ts_value, 32'h55D7EB21);
    tick();
    check("t1_c4_done", {30'd0, done, busy}, 32'd0);

    // 2: ID mismatch still reads the timestamp
    id_word = 32'h12345678;
    pulse_start();
    wait_done(1'b0, 1, 40, at);
    check("t2_done_cycle", at, 32'd3);
    check("t2_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd2);
    check("t2_id_value", id_value, 32'h12345678);
    check("t2_ts_value", ts_value, 32'h55D7EB21);
    id_word = 32'hACD51302;
    tick();

    // 6: start while busy and on the done cycle is ignored
    pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, 2, 40, at);
    check("t6_done_cycle", at, 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dones++;
      tick();
    end
    check("t6_no_restart", dones, 32'd0);
    check("t6_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);

    // 3: five wait cycles per read, request held stable
    stall_n = 5;
    pulse_start();
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("t3_id_hold_c%0d", i), {30'd0, avm_read, avm_address}, 32'd2);
      tick();
    end
    for (int i = 7; i <= 12; i++) begin
      check($sformatf("t3_ts_hold_c%0d", i), {30'd0, avm_read, avm_address}, 32'd3);
      tick();
    end
    wait_done(1'b0, 13, 60, at);
    check("t3_done_cycle", at, 32'd13);
    check("t3_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    tick();

    // 5: reset during a stalled ID read, then a clean rerun
    stall_n = 1000;
    pulse_start();
    tick();
    check("t5_pre_read", {31'd0, avm_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_read", {31'd0, avm_read}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    stall_n = 0;
    tick();
    pulse_start();
    wait_done(1'b0, 1, 40, at);
    check("t5_done_cycle", at, 32'd3);
    check("t5_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    check("t5_ts_value", ts_value, 32'h55D7EB21);
    tick();

    // 4: latency 2, timeout 4, timestamp read stuck
    stuck2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("t4_c1_read", {30'd0, avm_read2, avm_address2}, 32'd2);
    tick();
    check("t4_c2_data", {30'd0, avm_read2, busy2}, 32'd1);
    wait_done(1'b1, 2, 40, at);
    check("t4_done_cycle", at, 32'd8);
    check("t4_flags", {29'd0, id_ok2, ts_ok2, timeout2}, 32'd5);
    check("t4_id_value", id_value2, 32'hACD51302);
    check("t4_ts_value", ts_value2, 32'd0);
    check("t4_fin_read", {30'd0, avm_read2, busy2}, 32'd0);
    tick();
    check("t4_single_done", {30'd0, done2, busy2}, 32'd0);
    check("t4_sticky", {31'd0, timeout2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
